inst_sequencer: RTL and testbench

Parametrised successor to the NPU's free-running PC counter. It fetches instructions from a synchronous instruction memory over a programmable address window [start_pc, end_pc]. Instructions are issued to the decode/execute stage over a valid/ready handshake. Nested hardware loops (LOOP/ENDLOOP) are resolved internally, and the block reports completion, abort and error. It sits between the host/control registers and the instruction decoder.

---
 rtl/inst_sequencer_if.sv | 30 +++
 rtl/inst_sequencer.sv | 167 ++++++++++++++++
 tb/tb_inst_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_sequencer_if.sv
// Host, instruction-memory and decoder signals of the instruction sequencer.
// master = sequencer side, slave = environment (host, imem, decoder).
interface inst_sequencer_if #(
  parameter int INST_LEN = 16,
  parameter int PC_WIDTH = 8
);
  logic                start;
  logic [PC_WIDTH-1:0] start_pc;
  logic [PC_WIDTH-1:0] end_pc;
  logic                abort;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [INST_LEN-1:0] imem_rdata;
  logic [INST_LEN-1:0] inst;
  logic                inst_valid;
  logic                inst_ready;
  logic [PC_WIDTH-1:0] PC;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    input  start, start_pc, end_pc, abort, imem_rdata, inst_ready,
    output imem_addr, inst, inst_valid, PC, busy, done, err
  );

  modport slave (
    output start, start_pc, end_pc, abort, imem_rdata, inst_ready,
    input  imem_addr, inst, inst_valid, PC, busy, done, err
  );
endinterface

// File: rtl/inst_sequencer.sv
// Windowed instruction fetch/issue with nested hardware loops; 3 cycles per issued instruction,
// 2 per LOOP/ENDLOOP; inst/inst_valid held stable while inst_ready is low.
module inst_sequencer #(
  parameter int INST_LEN   = 16,
  parameter int PC_WIDTH   = 8,
  parameter int LOOP_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input logic              clk,
  input logic              rst,
  inst_sequencer_if.master bus
);
  localparam int DW = $clog2(LOOP_DEPTH + 1);
  localparam int IW = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
  localparam logic [3:0] OP_LOOP = 4'hE;
  localparam logic [3:0] OP_END  = 4'hF;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic [PC_WIDTH-1:0] end_q, end_nxt;
  logic [INST_LEN-1:0] inst_q, inst_nxt;
  logic                vld_q, vld_nxt;
  logic                err_q, err_nxt;
  logic [DW-1:0]       depth, depth_nxt;

  logic [PC_WIDTH-1:0]  body_stk [LOOP_DEPTH];
  logic [CNT_WIDTH-1:0] rem_stk  [LOOP_DEPTH];

  logic                 push, dec_top, adv;
  logic [IW-1:0]        push_idx, top_idx;
  logic [3:0]           opcode;
  logic [CNT_WIDTH-1:0] count, push_rem;

  assign opcode   = bus.imem_rdata[INST_LEN-1 -: 4];
  assign count    = bus.imem_rdata[CNT_WIDTH-1:0];
  // A zero count runs the body once, so it stores the same remaining value as a count of 1.
  assign push_rem = (count == '0) ? '0 : count - 1'b1;
  assign push_idx = depth[IW-1:0];
  assign top_idx  = push_idx - 1'b1;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    end_nxt   = end_q;
    inst_nxt  = inst_q;
    vld_nxt   = vld_q;
    err_nxt   = err_q;
    depth_nxt = depth;
    push      = 1'b0;
    dec_top   = 1'b0;
    adv       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          pc_nxt    = bus.start_pc;
          end_nxt   = bus.end_pc;
          err_nxt   = 1'b0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LOOP) begin
          if (depth == DW'(LOOP_DEPTH)) begin
            err_nxt   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            push      = 1'b1;
            depth_nxt = depth + 1'b1;
            adv       = 1'b1;
          end
        end else if (opcode == OP_END) begin
          if (depth == '0) begin
            err_nxt   = 1'b1;
            state_nxt = S_DONE;
          end else if (rem_stk[top_idx] != '0) begin
            // Jumping back skips the end-of-window check: the body lies inside the window.
            dec_top   = 1'b1;
            pc_nxt    = body_stk[top_idx];
            state_nxt = S_FETCH;
          end else begin
            depth_nxt = depth - 1'b1;
            adv       = 1'b1;
          end
        end else begin
          inst_nxt  = bus.imem_rdata;
          vld_nxt   = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.inst_ready) begin
          vld_nxt = 1'b0;
          adv     = 1'b1;
        end
      end
      S_DONE: begin
        pc_nxt    = '0;
        depth_nxt = '0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (adv) begin
      if (pc == end_q) begin
        state_nxt = S_DONE;
      end else begin
        pc_nxt    = pc + 1'b1;
        state_nxt = S_FETCH;
      end
    end

    // Abort wins over everything, including an error found in the same DECODE.
    if (bus.abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      pc_nxt    = '0;
      vld_nxt   = 1'b0;
      depth_nxt = '0;
      err_nxt   = err_q;
      push      = 1'b0;
      dec_top   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= '0;
      end_q  <= '0;
      inst_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      depth  <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      end_q  <= end_nxt;
      inst_q <= inst_nxt;
      vld_q  <= vld_nxt;
      err_q  <= err_nxt;
      depth  <= depth_nxt;
    end
  end

  // Stack contents need no reset; depth alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      body_stk[push_idx] <= pc + 1'b1;
      rem_stk[push_idx]  <= push_rem;
    end
    if (dec_top) begin
      rem_stk[top_idx] <= rem_stk[top_idx] - 1'b1;
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.PC         = pc;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = vld_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.err        = err_q;
endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: a program-level reference model predicts the issue stream,
// error flag and run length; one negedge process compares the DUT against it.
module tb_inst_sequencer;
  localparam int DEPTH = 2;

  logic clk;
  logic rst;

  inst_sequencer_if #(.INST_LEN(16), .PC_WIDTH(8)) bus ();

  inst_sequencer #(
    .INST_LEN(16), .PC_WIDTH(8), .LOOP_DEPTH(DEPTH), .CNT_WIDTH(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] mem [256];
  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

  // Reference model results
  logic [23:0] exp_q [$];
  int   m_ctrl, m_iss;
  logic m_err, m_bad;

  int   checks = 0;
  int   errors = 0;
  int   run_cyc, hs_cnt, stalls, done_cnt, first_vld, done_cyc;
  int   rdy_mode = 0;
  bit   armed = 0;
  bit   prev_stall = 0;
  logic [15:0] prev_inst;
  logic [7:0]  prev_pc, cur_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Interpret the program in the window: what is issued, in what order, and how it ends.
  task automatic model_run(input logic [7:0] s, input logic [7:0] e);
    int pc, steps, n;
    int sb[$];
    int sr[$];
    logic [15:0] w;
    bit adv;
    exp_q.delete();
    m_err = 0; m_bad = 0; m_ctrl = 0; m_iss = 0;
    pc = int'(s); steps = 0;
    while (1) begin
      w = mem[pc];
      adv = 1;
      if (w[15:12] == 4'hE) begin
        m_ctrl++;
        if (sb.size() == DEPTH) begin m_err = 1; break; end
        n = (w[7:0] == 8'd0) ? 1 : int'(w[7:0]);
        sb.push_back((pc + 1) % 256);
        sr.push_back(n - 1);
      end else if (w[15:12] == 4'hF) begin
        m_ctrl++;
        if (sb.size() == 0) begin m_err = 1; break; end
        if (sr[sr.size()-1] != 0) begin
          sr[sr.size()-1] = sr[sr.size()-1] - 1;
          pc = sb[sb.size()-1];
          adv = 0;
        end else begin
          void'(sb.pop_back());
          void'(sr.pop_back());
        end
      end else begin
        m_iss++;
        exp_q.push_back({pc[7:0], w});
      end
      if (adv) begin
        if (pc == int'(e)) break;
        pc = (pc + 1) % 256;
      end
      steps++;
      if (steps > 2000) begin m_bad = 1; break; end
    end
  endtask

  // inst_ready driver: 0 always ready, 1 random, 2 stall 2nd instruction 5 cycles, else never ready
  initial begin
    bus.inst_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.inst_ready = 1'b1;
        1:       bus.inst_ready = ($urandom_range(0, 3) != 0);
        2:       bus.inst_ready = !(hs_cnt == 1 && stalls < 5);
        default: bus.inst_ready = 1'b0;
      endcase
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (armed) begin
      run_cyc++;
      chk("busy_in_run", bus.busy, 1);
      if (run_cyc == 1) begin
        chk("fetch_addr_c1", bus.imem_addr, cur_s);
        chk("err_cleared_c1", bus.err, 0);
      end
      if (prev_stall) begin
        chk("hold_vld", bus.inst_valid, 1);
        chk("hold_inst", bus.inst, prev_inst);
        chk("hold_pc", bus.PC, prev_pc);
      end
      prev_stall = bus.inst_valid && !bus.inst_ready;
      prev_inst  = bus.inst;
      prev_pc    = bus.PC;
      if (bus.inst_valid) begin
        if (first_vld == 0) first_vld = run_cyc;
        if (bus.inst_ready) begin
          chk("issue_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("issue_pc_inst", {bus.PC, bus.inst}, exp_q.pop_front());
          hs_cnt++;
        end else begin
          stalls++;
        end
      end
      if (bus.done) begin
        chk("done_once", done_cnt, 0);
        done_cnt++;
        done_cyc = run_cyc;
        chk("done_err", bus.err, m_err);
        chk("done_cycle", run_cyc, 2 * m_ctrl + 3 * m_iss + stalls + 1);
        chk("issues_left", exp_q.size(), 0);
      end
    end
  end

  task automatic launch(input logic [7:0] s, input logic [7:0] e, input int mode);
    model_run(s, e);
    rdy_mode = mode; hs_cnt = 0; stalls = 0; done_cnt = 0; first_vld = 0;
    prev_stall = 0; cur_s = s;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_pc = s; bus.end_pc = e;
    @(posedge clk); #1;
    bus.start = 1'b0; run_cyc = 0; armed = 1;
  endtask

  task automatic run(input logic [7:0] s, input logic [7:0] e, input int mode);
    launch(s, e, mode);
    for (int k = 0; k < 4000 && done_cnt == 0; k++) @(posedge clk);
    armed = 0;
    chk("done_seen", done_cnt, 1);
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_pc", bus.PC, 0);
    chk("idle_vld", bus.inst_valid, 0);
    chk("idle_done", bus.done, 0);
    chk("idle_err", bus.err, m_err);
  endtask

  initial begin
    logic [35:0] sq;
    logic [31:0] ad;
    logic [7:0]  s, e;
    int r;
    rst = 1'b1;
    bus.start = 1'b0; bus.start_pc = '0; bus.end_pc = '0; bus.abort = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_vld", bus.inst_valid, 0);
    chk("rst_inst", bus.inst, 0);
    chk("rst_pc", bus.PC, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;

    // Linear run 2..5
    mem[2] = 16'h1234; mem[3] = 16'h2345; mem[4] = 16'h3456; mem[5] = 16'h4567;
    model_run(8'd2, 8'd5);
    chk("model_lin_iss", m_iss, 4);
    run(8'd2, 8'd5, 0);
    chk("lin_first_vld", first_vld, 3);
    chk("lin_done_cyc", done_cyc, 13);

    // Backpressure on the 2nd instruction
    run(8'd2, 8'd5, 2);
    chk("bp_stalls", stalls, 5);
    chk("bp_done_cyc", done_cyc, 18);

    // Nested loops: LOOP3 { A, LOOP2 { B } ENDLOOP } ENDLOOP
    mem[8'h10] = 16'hE003; mem[8'h11] = 16'h1AAA; mem[8'h12] = 16'hE002;
    mem[8'h13] = 16'h2BBB; mem[8'h14] = 16'hF000; mem[8'h15] = 16'hF000;
    model_run(8'h10, 8'h15);
    sq = '0;
    foreach (exp_q[i]) sq = {sq[31:0], exp_q[i][15:12]};
    chk("model_nest_seq", sq, 36'h122122122);
    chk("model_nest_err", m_err, 0);
    run(8'h10, 8'h15, 0);
    chk("nest_done_cyc", done_cyc, 54);

    // Loop overflow with nesting limit 2
    mem[8'h20] = 16'hE001; mem[8'h21] = 16'hE001; mem[8'h22] = 16'hE001;
    mem[8'h23] = 16'h1111; mem[8'h24] = 16'hF000; mem[8'h25] = 16'hF000; mem[8'h26] = 16'hF000;
    model_run(8'h20, 8'h26);
    chk("model_ovf_err", m_err, 1);
    chk("model_ovf_iss", m_iss, 0);
    run(8'h20, 8'h26, 0);
    chk("ovf_done_cyc", done_cyc, 7);

    // Lone ENDLOOP, then a clean run clears err
    mem[8'h30] = 16'hF000; mem[8'h31] = 16'h1000;
    run(8'h30, 8'h31, 0);
    chk("lone_done_cyc", done_cyc, 3);
    run(8'd2, 8'd5, 0);

    // Window wrapping through 0
    mem[8'hFE] = 16'h5001; mem[8'hFF] = 16'h6002; mem[8'h00] = 16'h7003; mem[8'h01] = 16'h8004;
    model_run(8'hFE, 8'h01);
    ad = '0;
    foreach (exp_q[i]) ad = {ad[23:0], exp_q[i][23:16]};
    chk("model_wrap_addrs", ad, 32'hFEFF0001);
    run(8'hFE, 8'h01, 0);

    // LOOP 0 runs its body once
    mem[8'h40] = 16'hE000; mem[8'h41] = 16'h3333; mem[8'h42] = 16'hF000;
    model_run(8'h40, 8'h42);
    chk("model_loop0_iss", m_iss, 1);
    run(8'h40, 8'h42, 0);
    chk("loop0_done_cyc", done_cyc, 8);

    // Abort while stalled in ISSUE
    launch(8'd2, 8'd5, 3);
    for (int k = 0; k < 20 && !bus.inst_valid; k++) @(negedge clk);
    chk("abort_reached_issue", bus.inst_valid, 1);
    @(posedge clk); #1;
    armed = 0; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_vld", bus.inst_valid, 0);
    chk("abort_pc", bus.PC, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_err", bus.err, 0);
    @(negedge clk);
    chk("abort_no_done_later", bus.done, 0);

    // Abort in IDLE blocks start
    @(posedge clk); #1;
    bus.abort = 1'b1; bus.start = 1'b1; bus.start_pc = 8'd2; bus.end_pc = 8'd5;
    @(posedge clk); #1;
    bus.abort = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("abort_blocks_start", bus.busy, 0);

    // Reset in the middle of the nested loop
    launch(8'h10, 8'h15, 0);
    for (int k = 0; k < 200 && hs_cnt < 3; k++) @(negedge clk);
    chk("rst_mid_reached", hs_cnt >= 3, 1);
    armed = 0;
    #2 rst = 1'b1;
    #1;
    chk("rstm_vld", bus.inst_valid, 0);
    chk("rstm_busy", bus.busy, 0);
    chk("rstm_pc", bus.PC, 0);
    chk("rstm_addr", bus.imem_addr, 0);
    chk("rstm_inst", bus.inst, 0);
    chk("rstm_done", bus.done, 0);
    chk("rstm_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    run(8'h10, 8'h15, 0);

    // Randomized programs
    for (int t = 0; t < 40; t++) begin
      s = 8'($urandom_range(0, 255));
      e = s + 8'($urandom_range(0, 7));
      for (logic [7:0] a = s; ; a++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      mem[a] = {4'($urandom_range(0, 13)), 12'($urandom)};
        else if (r < 8) mem[a] = {8'hE0, 8'($urandom_range(0, 3))};
        else            mem[a] = {4'hF, 12'($urandom)};
        if (a == e) break;
      end
      model_run(s, e);
      if (!m_bad) run(s, e, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
